// File: rtl/sbox_layer_sequencer.sv
// sbox_layer_sequencer
// Sequences one 3-share state through an external masked S-box layer of
// fixed latency LAT. It registers the shares, waits LAT cycles while feeding
// the layer fresh randomness from a 216-bit LFSR, then captures the result
// shares and holds them until downstream accepts them.
// The three shares are only ever moved as separate words and are never
// combined with each other.
// Optional feature: define SBOX_SEQ_RESEED_EN to add the seed_valid/seed
// ports, which reload the LFSR while the block is idle.
module sbox_layer_sequencer #(
   parameter int           LAT  = 3,
   parameter logic [215:0] SEED = 216'h1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_sel,
   input  logic [63:0]  in_share1,
   input  logic [63:0]  in_share2,
   input  logic [63:0]  in_share3,
   output logic [63:0]  st1,
   output logic [63:0]  st2,
   output logic [63:0]  st3,
   output logic         sel,
   output logic [215:0] r,
   input  logic [63:0]  res1,
   input  logic [63:0]  res2,
   input  logic [63:0]  res3,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  out_share1,
   output logic [63:0]  out_share2,
   output logic [63:0]  out_share3
`ifdef SBOX_SEQ_RESEED_EN
   ,
   input  logic         seed_valid,
   input  logic [215:0] seed
`endif
);

   localparam int           CW       = $clog2(LAT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);
   // An all-zero LFSR would lock up, so zero seeds become 1.
   localparam logic [215:0] SEED_NZ  = (SEED == 216'h0) ? 216'h1 : SEED;

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic          xfer;
   logic          wait_done;
   logic          lfsr_fb;
   logic [215:0]  r_shift;
   logic [215:0]  r_nx;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == HOLD);
   assign xfer      = in_valid & in_ready;
   assign wait_done = (state == WAIT) && (cnt == CNT_LAST);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state: IDLE -> WAIT on transfer, WAIT -> HOLD after LAT cycles,
   // HOLD -> IDLE once downstream takes the result
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (xfer)      state_nx = WAIT;
         WAIT:    if (wait_done) state_nx = HOLD;
         HOLD:    if (out_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   // WAIT cycle counter, restarted by every transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            cnt <= '0;
      else if (xfer)                      cnt <= '0;
      else if (state == WAIT && !wait_done) cnt <= cnt + CW'(1);
   end

   // Input shares and select, frozen for the whole transaction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st1 <= '0;
         st2 <= '0;
         st3 <= '0;
         sel <= 1'b0;
      end else if (xfer) begin
         st1 <= in_share1;
         st2 <= in_share2;
         st3 <= in_share3;
         sel <= in_sel;
      end
   end

   // Result shares captured on the edge ending the last WAIT cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_share1 <= '0;
         out_share2 <= '0;
         out_share3 <= '0;
      end else if (wait_done) begin
         out_share1 <= res1;
         out_share2 <= res2;
         out_share3 <= res3;
      end
   end

   assign lfsr_fb = r[215] ^ r[214] ^ r[209] ^ r[208];
   assign r_shift = {r[214:0], lfsr_fb};

   // LFSR next value: advance only in WAIT; an idle reseed overrides the hold
   always_comb begin
      r_nx = r;
      if (state == WAIT)
         r_nx = (r_shift == 216'h0) ? 216'h1 : r_shift;
`ifdef SBOX_SEQ_RESEED_EN
      if (state == IDLE && seed_valid)
         r_nx = (seed == 216'h0) ? 216'h1 : seed;
`endif
   end

   // LFSR register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r <= SEED_NZ;
      else     r <= r_nx;
   end

endmodule

// File: tb/tb_sbox_layer_sequencer.sv
// Bench for sbox_layer_sequencer: random transactions scored against a
// queue of expected results, with a stand-in S-box layer whose outputs are
// only meaningful on the exact capture edge.
module tb_sbox_layer_sequencer;
   localparam int           LAT  = 3;
   localparam logic [215:0] SEED = 216'h1;

   logic clk = 0, rst = 1;
   logic in_valid = 0, in_ready, in_sel = 0;
   logic [63:0] in_share1 = 0, in_share2 = 0, in_share3 = 0;
   logic [63:0] st1, st2, st3;
   logic sel;
   logic [215:0] r;
   logic [63:0] res1 = 0, res2 = 0, res3 = 0;
   logic out_valid, out_ready = 0;
   logic [63:0] out_share1, out_share2, out_share3;
`ifdef SBOX_SEQ_RESEED_EN
   logic seed_valid = 0;
   logic [215:0] seed = 0;
`endif

   sbox_layer_sequencer #(.LAT(LAT), .SEED(SEED)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
      .in_share1(in_share1), .in_share2(in_share2), .in_share3(in_share3),
      .st1(st1), .st2(st2), .st3(st3), .sel(sel), .r(r),
      .res1(res1), .res2(res2), .res3(res3),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_share1(out_share1), .out_share2(out_share2), .out_share3(out_share3)
`ifdef SBOX_SEQ_RESEED_EN
      , .seed_valid(seed_valid), .seed(seed)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0]  s1, s2, s3;
      logic         sel;
      logic [63:0]  o1, o2, o3;
      logic [215:0] rh;
      int           xc;
   } exp_t;

   exp_t q[$];
   int checks = 0, fails = 0;
   int cyc = 0;
   logic [215:0] model_r = SEED;

   // Per-share layer functions: each result share depends on its own share only
   function automatic logic [63:0] f1(input logic [63:0] s, input logic x);
      return {s[62:0], s[63]} ^ {64{x}};
   endfunction
   function automatic logic [63:0] f2(input logic [63:0] s, input logic x);
      return s ^ 64'h5A5A_C3C3_0F0F_9696 ^ {63'h0, x};
   endfunction
   function automatic logic [63:0] f3(input logic [63:0] s, input logic x);
      return ~s + {63'h0, x};
   endfunction

   // LFSR reference: n steps of the Fibonacci recurrence
   function automatic logic [215:0] adv(input logic [215:0] x, input int n);
      logic fb;
      for (int i = 0; i < n; i++) begin
         fb = x[215] ^ x[214] ^ x[209] ^ x[208];
         x  = {x[214:0], fb};
         if (x == 216'h0) x = 216'h1;
      end
      return x;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic chk(input string nm, input logic [215:0] act, input logic [215:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Stand-in layer: correct result only for the sample at edge T+LAT
   int age = 1000;
   always @(posedge clk) begin
      if (rst) age = 1000;
      else if (in_valid && in_ready) age = 0;
      else if (age < 1000) age++;
      #1;
      if (age == LAT - 1) begin
         res1 = f1(st1, sel); res2 = f2(st2, sel); res3 = f3(st3, sel);
      end else begin
         res1 = rnd64(); res2 = rnd64(); res3 = rnd64();
      end
   end

   // Monitor: compares everything the DUT presents against the queue front
   logic [215:0] idle_r = SEED;
   logic prev_v = 0;
   always @(negedge clk) begin
      if (rst) begin
         idle_r = SEED;
         prev_v = 0;
      end else begin
         if (out_valid) begin
            if (q.size() == 0) chk("unexpected_out_valid", out_valid, 1'b0);
            else begin
               chk("out_share1", out_share1, q[0].o1);
               chk("out_share2", out_share2, q[0].o2);
               chk("out_share3", out_share3, q[0].o3);
               chk("r_in_hold", r, q[0].rh);
               chk("in_ready_in_hold", in_ready, 1'b0);
               if (!prev_v) chk("out_valid_latency", cyc, q[0].xc + LAT);
            end
         end else if (in_ready) begin
            chk("r_in_idle", r, idle_r);
         end
         if (!in_ready && q.size() > 0) begin
            chk("st1_held", st1, q[0].s1);
            chk("st2_held", st2, q[0].s2);
            chk("st3_held", st3, q[0].s3);
            chk("sel_held", sel, q[0].sel);
         end
         if (out_valid && out_ready && q.size() > 0) begin
            idle_r = q[0].rh;
            void'(q.pop_front());
         end
         prev_v = out_valid;
      end
   end

   // Drive one cycle (called just after a rising edge); push expectation on transfer
   task automatic step(input logic v, input logic [63:0] a, b, c, input logic s, input logic ordy);
      exp_t e;
      logic [215:0] base;
      in_valid = v; in_share1 = a; in_share2 = b; in_share3 = c; in_sel = s; out_ready = ordy;
      @(negedge clk);
      if (in_valid && in_ready && !rst) begin
         base = model_r;
`ifdef SBOX_SEQ_RESEED_EN
         if (seed_valid) base = (seed == 216'h0) ? 216'h1 : seed;
`endif
         e.s1 = a; e.s2 = b; e.s3 = c; e.sel = s;
         e.o1 = f1(a, s); e.o2 = f2(b, s); e.o3 = f3(c, s);
         e.rh = adv(base, LAT);
         e.xc = cyc + 1;
         model_r = e.rh;
         q.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   task automatic rnd_step(input int vpct, input int rpct);
      step($urandom_range(99) < vpct, rnd64(), rnd64(), rnd64(), 1'($urandom), $urandom_range(99) < rpct);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && !in_ready; i++) step(0, 0, 0, 0, 0, 1);
      chk("wait_idle_timeout", in_ready, 1'b1);
   endtask

   initial begin
      rst = 1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_st1", st1, 0);
      chk("rst_st2", st2, 0);
      chk("rst_st3", st3, 0);
      chk("rst_sel", sel, 0);
      chk("rst_out_share1", out_share1, 0);
      chk("rst_out_share2", out_share2, 0);
      chk("rst_out_share3", out_share3, 0);
      chk("rst_r", r, SEED);
      @(posedge clk); #1 rst = 0;

      // Transfer on the first edge after reset release
      step(1, 64'h0123456789ABCDEF, 0, 0, 1, 0);
      chk("first_st1", st1, 64'h0123456789ABCDEF);
      chk("first_sel", sel, 1'b1);
      repeat (LAT) step(0, 0, 0, 0, 0, 0);
      chk("first_out_valid", out_valid, 1'b1);
      chk("first_r_after_wait", r, 216'h8);

      // Backpressure in HOLD with new input offered the whole time
      repeat (10) step(1, rnd64(), rnd64(), rnd64(), 1, 0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      step(0, 0, 0, 0, 0, 1);
      chk("bp_released_idle", in_ready, 1'b1);

      // Busy input offered through a whole transaction
      step(1, rnd64(), rnd64(), rnd64(), 0, 0);
      repeat (LAT + 3) rnd_step(100, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) rnd_step(70, 60);
      for (int i = 0; i < 60; i++) rnd_step(90, 5);

      // Reset during cycle 2 of WAIT
      wait_idle();
      step(1, rnd64(), rnd64(), rnd64(), 1, 1);
      step(0, 0, 0, 0, 0, 1);
      rst = 1;
      q.delete();
      model_r = SEED;
      @(negedge clk);
      chk("midwait_rst_r", r, SEED);
      chk("midwait_rst_out_valid", out_valid, 1'b0);
      chk("midwait_rst_in_ready", in_ready, 1'b1);
      @(posedge clk); #1 rst = 0;
      for (int i = 0; i < 80; i++) rnd_step(70, 70);

`ifdef SBOX_SEQ_RESEED_EN
      wait_idle();
      seed_valid = 1; seed = 216'h0;
      step(1, rnd64(), rnd64(), rnd64(), 0, 0);
      seed_valid = 0;
      chk("reseed_r_wait_start", r, 216'h1);
      repeat (LAT) step(0, 0, 0, 0, 0, 0);
      chk("reseed_r_after_wait", r, 216'h8);
      step(0, 0, 0, 0, 0, 1);
`endif

      // Drain
      for (int i = 0; i < 40 && q.size() > 0; i++) step(0, 0, 0, 0, 0, 1);
      chk("drain_queue_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
